// File: rtl/dd_pkg.sv
// Shared constants for the sequential double-dabble converter: FSM encoding, digit width and sizing helpers.
package dd_pkg;

  localparam int unsigned DD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    DD_IDLE  = 2'd0,
    DD_SHIFT = 2'd1,
    DD_DONE  = 2'd2
  } dd_state_e;

  function automatic int unsigned dd_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Number of decimal digits needed to show 2^width-1.
  function automatic int unsigned dd_min_digits(input int unsigned width);
    logic [63:0]  max_v;
    logic [63:0]  p;
    int unsigned  d;
    max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    d     = 1;
    p     = 64'd10;
    for (int i = 0; i < 19; i++) begin
      if (p <= max_v) begin
        d = d + 1;
        p = p * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/dd_digit_adj.sv
// One BCD digit correction step: adds 3 to digits of 5 or more so the next left shift carries decimally.
module dd_digit_adj
  import dd_pkg::*;
(
  input  logic [DD_DIGIT_W-1:0] digit_i,
  output logic [DD_DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
  end

endmodule

// File: rtl/double_dabble_seq.sv
// Binary-to-BCD, one bit per clock; result valid WIDTH edges after accept, held in DONE until out_ready_i.
// Optional DD_SIGNED_EN: treat in_data_i as two's complement, convert the magnitude and flag neg_o.
module double_dabble_seq
  import dd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = dd_min_digits(WIDTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [DD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic                         ovf_o,
  output logic                         neg_o
);

  localparam int unsigned     BCD_W    = DD_DIGIT_W * DIGITS;
  localparam int unsigned     CNT_W    = dd_clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  dd_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [WIDTH-1:0] operand;
  logic             accept;
  logic             carry;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dd_digit_adj u_adj (
      .digit_i (bcd_q[g*DD_DIGIT_W +: DD_DIGIT_W]),
      .digit_o (bcd_adj[g*DD_DIGIT_W +: DD_DIGIT_W])
    );
  end

`ifdef DD_SIGNED_EN
  logic neg_q;
  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign operand = in_data_i[WIDTH-1] ? ((~in_data_i) + WIDTH'(1)) : in_data_i;

  always_ff @(posedge clk_i) begin
    if (rst_i)       neg_q <= 1'b0;
    else if (accept) neg_q <= in_data_i[WIDTH-1];
  end

  assign neg_o = neg_q;
`else
  assign operand = in_data_i;
  assign neg_o   = 1'b0;
`endif

  assign accept = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DD_IDLE;
      count_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DD_IDLE:  if (accept)                state_d = DD_SHIFT;
      DD_SHIFT: if (count_q == LAST_CNT)   state_d = DD_DONE;
      DD_DONE:  if (out_ready_i)           state_d = DD_IDLE;
      default:                             state_d = DD_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    carry   = 1'b0;
    if (accept) begin
      bin_d   = operand;
      bcd_d   = '0;
      ovf_d   = 1'b0;
      count_d = '0;
    end else if (state_q == DD_SHIFT) begin
      // A bit leaving the top digit means the value no longer fits in DIGITS.
      {carry, bcd_d, bin_d} = {bcd_adj, bin_q, 1'b0};
      ovf_d   = ovf_q | carry;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready_o  = (state_q == DD_IDLE) && !rst_i;
    out_valid_o = (state_q == DD_DONE);
    bcd_o       = bcd_q;
    ovf_o       = ovf_q;
  end

endmodule

// File: tb/tb_double_dabble_seq.sv
// Drives three converter configurations and checks results against an arithmetic decimal model.
module tb_double_dabble_seq;
  import dd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv0, iv1, iv2, or0, or1, or2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic        ovf0, ovf1, ovf2, neg0, neg1, neg2;
  logic [15:0] d16;
  logic [7:0]  d8a, d8b;
  logic [19:0] b16;
  logic [11:0] b8a;
  logic [7:0]  b8b;

  int checks = 0;
  int errors = 0;

  double_dabble_seq #(.WIDTH(16), .DIGITS(5)) u16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(d16),
    .out_valid_o(ov0), .out_ready_i(or0), .bcd_o(b16), .ovf_o(ovf0), .neg_o(neg0));

  double_dabble_seq #(.WIDTH(8), .DIGITS(3)) u8a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv1), .in_ready_o(ir1), .in_data_i(d8a),
    .out_valid_o(ov1), .out_ready_i(or1), .bcd_o(b8a), .ovf_o(ovf1), .neg_o(neg1));

  double_dabble_seq #(.WIDTH(8), .DIGITS(2)) u8b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv2), .in_ready_o(ir2), .in_data_i(d8b),
    .out_valid_o(ov2), .out_ready_i(or2), .bcd_o(b8b), .ovf_o(ovf2), .neg_o(neg2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] get_bcd(input int w);
    case (w)
      0:       return b16;
      1:       return {8'h0, b8a};
      default: return {12'h0, b8b};
    endcase
  endfunction
  function automatic logic get_ir(input int w);
    return (w == 0) ? ir0 : (w == 1) ? ir1 : ir2;
  endfunction
  function automatic logic get_ov(input int w);
    return (w == 0) ? ov0 : (w == 1) ? ov1 : ov2;
  endfunction
  function automatic logic get_ovf(input int w);
    return (w == 0) ? ovf0 : (w == 1) ? ovf1 : ovf2;
  endfunction
  function automatic logic get_neg(input int w);
    return (w == 0) ? neg0 : (w == 1) ? neg1 : neg2;
  endfunction

  task automatic set_iv(input int w, input logic v);
    if (w == 0) iv0 = v; else if (w == 1) iv1 = v; else iv2 = v;
  endtask
  task automatic set_or(input int w, input logic v);
    if (w == 0) or0 = v; else if (w == 1) or1 = v; else or2 = v;
  endtask
  task automatic set_data(input int w, input logic [15:0] raw);
    if (w == 0) d16 = raw; else if (w == 1) d8a = raw[7:0]; else d8b = raw[7:0];
  endtask

  // Decimal digits of v by repeated division, packed units-first.
  function automatic logic [19:0] model_bcd(input longint unsigned v, input int digits);
    logic [19:0]      r;
    longint unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < digits; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One full transaction: offer word, measure latency, check result, stall, release.
  task automatic run(input int w, input logic [15:0] raw, input int hold);
    int              wd, dg, n;
    longint unsigned dv, mag, lim;
    logic            exp_neg, exp_ovf;
    logic [19:0]     exp_bcd, snap;
    wd = (w == 0) ? 16 : 8;
    dg = (w == 0) ? 5 : (w == 1) ? 3 : 2;
    dv = longint'(raw) & ((64'd1 << wd) - 1);
    exp_neg = 1'b0;
    mag     = dv;
`ifdef DD_SIGNED_EN
    if (dv >= (64'd1 << (wd - 1))) begin
      exp_neg = 1'b1;
      mag     = (64'd1 << wd) - dv;
    end
`endif
    lim = 1;
    for (int i = 0; i < dg; i++) lim = lim * 10;
    exp_ovf = (mag >= lim);
    exp_bcd = model_bcd(mag, dg);

    @(negedge clk);
    set_data(w, raw);
    set_iv(w, 1'b1);
    n = 0;
    while (!get_ir(w) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", get_ir(w), 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_iv(w, 1'b0);
    n = 0;
    while (!get_ov(w) && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("latency", n, wd);
    chk("ovf", get_ovf(w), exp_ovf);
    chk("neg", get_neg(w), exp_neg);
    if (!exp_ovf) chk("bcd", get_bcd(w), exp_bcd);

    // in_valid stays high through DONE; it must not be taken until back in IDLE.
    snap = get_bcd(w);
    set_iv(w, 1'b1);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_bcd", get_bcd(w), snap);
      chk("hold_valid", get_ov(w), 1'b1);
      chk("hold_in_ready", get_ir(w), 1'b0);
    end
    set_or(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_iv(w, 1'b0);
    set_or(w, 1'b0);
    chk("release_valid", get_ov(w), 1'b0);
    chk("release_idle", get_ir(w), 1'b1);
  endtask

  initial begin
    int   n;
    logic seen;
    rst = 1'b1;
    {iv0, iv1, iv2, or0, or1, or2} = '0;
    d16 = '0; d8a = '0; d8b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {ir0, ir1, ir2}, 3'b000);
    chk("rst_out_valid", {ov0, ov1, ov2}, 3'b000);
    chk("rst_bcd16", b16, 20'h0);
    chk("rst_bcd8", {b8a, b8b}, 20'h0);
    chk("rst_flags", {ovf0, ovf1, ovf2, neg0, neg1, neg2}, 6'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {ir0, ir1, ir2}, 3'b111);
    chk("min_digits16", dd_min_digits(16), 5);
    chk("min_digits8", dd_min_digits(8), 3);

    run(1, 16'd255, 1);
`ifndef DD_SIGNED_EN
    chk("lit_255", b8a, 12'h255);
`endif
    run(0, 16'hFFFF, 0);
`ifndef DD_SIGNED_EN
    chk("lit_65535", b16, 20'h65535);
`endif
    run(0, 16'd0, 2);
    chk("lit_zero", b16, 20'h0);
    run(2, 16'd100, 0);
    run(2, 16'd99, 20);
    chk("lit_99", b8b, 8'h99);
    run(0, 16'h8000, 1);
`ifdef DD_SIGNED_EN
    chk("lit_min_neg", b16, 20'h32768);
`endif

    // Reset partway through a conversion must drop the result entirely.
    @(negedge clk);
    d16 = 16'd4321;
    iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", ir0, 1'b0);
    chk("midrst_bcd", b16, 20'h0);
    rst = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ov0) seen = 1'b1;
    end
    chk("midrst_no_emit", seen, 1'b0);
    run(0, 16'd1234, 1);
    chk("lit_1234", b16, 20'h01234);

    for (int i = 0; i < 30; i++) begin
      run(int'($urandom_range(0, 2)), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
